// File: rtl/ifft_frame_feeder.sv
// Buffers one complete spectrum frame from the resampler, then replays it in
// bin-index order as an AXI-Stream master into the IFFT, honouring tready.
//
// state | meaning
// IDLE  | waiting for the first bin of a new frame, bin_ready high
// FILL  | collecting bins into the frame buffer until bin_last
// DRAIN | replaying the buffer in index order, bin_ready low
module ifft_frame_feeder #(
    parameter int DATA_WIDTH = 80,
    parameter int ADDR_WIDTH = 12,
    parameter int N_BINS     = 4096
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] bin_data,
    input  logic [ADDR_WIDTH-1:0] bin_k,
    input  logic                  bin_valid,
    input  logic                  bin_last,
    output logic                  bin_ready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  frame_done,
    output logic                  overrun_err,
    output logic                  length_err,
    input  logic                  err_clear
);

    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(N_BINS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(N_BINS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH:0]   wr_count;
    logic [ADDR_WIDTH:0]   wr_next;
    logic                  wr_en;
    logic                  len_fault;

    logic [DATA_WIDTH-1:0] mem [N_BINS];
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_done;
    logic                  rd_en;
    logic                  rd_valid;
    logic                  rd_last;

    logic [DATA_WIDTH-1:0] skid_data;
    logic                  skid_valid;
    logic                  skid_last;

    logic                  pop;
    logic [1:0]            occupancy;
    logic [1:0]            occupancy_after_pop;

    assign wr_en     = bin_valid && bin_ready;
    assign wr_next   = (state == IDLE) ? (ADDR_WIDTH + 1)'(1) : wr_count + (ADDR_WIDTH + 1)'(1);
    assign len_fault = wr_en && bin_last && (wr_next != FULL_COUNT);

    assign pop        = m_axis_tvalid && m_axis_tready;
    assign frame_done = pop && m_axis_tlast;

    // Reads in flight count against the two output slots, so a read is only
    // issued when its data is guaranteed a place to land.
    assign occupancy           = 2'(m_axis_tvalid) + 2'(skid_valid) + 2'(rd_valid);
    assign occupancy_after_pop = occupancy - 2'(pop);
    assign rd_en               = (state == DRAIN) && !rd_done && (occupancy_after_pop < 2'd2);

    // Frame buffer: no reset, so contents survive reset_n.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[bin_k] <= bin_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bin_ready   <= 1'b1;
            wr_count    <= '0;
            rd_addr     <= '0;
            rd_done     <= 1'b0;
            overrun_err <= 1'b0;
            length_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bin_valid) begin
                        wr_count <= wr_next;
                        if (bin_last) begin
                            state     <= DRAIN;
                            bin_ready <= 1'b0;
                            rd_addr   <= '0;
                            rd_done   <= 1'b0;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (bin_valid) begin
                        wr_count <= wr_next;
                        if (bin_last) begin
                            state     <= DRAIN;
                            bin_ready <= 1'b0;
                            rd_addr   <= '0;
                            rd_done   <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (rd_en) begin
                        rd_addr <= rd_addr + ADDR_WIDTH'(1);
                        if (rd_addr == LAST_ADDR) begin
                            rd_done <= 1'b1;
                        end
                    end
                    if (frame_done) begin
                        state     <= IDLE;
                        bin_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bin_ready <= 1'b1;
                end
            endcase

            if (err_clear) begin
                overrun_err <= 1'b0;
                length_err  <= 1'b0;
            end else begin
                if (bin_valid && !bin_ready) begin
                    overrun_err <= 1'b1;
                end
                if (len_fault) begin
                    length_err <= 1'b1;
                end
            end
        end
    end

    // Output register plus one skid entry; RAM data always has a slot to go to.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid      <= 1'b0;
            rd_last       <= 1'b0;
            skid_valid    <= 1'b0;
            skid_data     <= '0;
            skid_last     <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_last  <= rd_en && (rd_addr == LAST_ADDR);

            if (!m_axis_tvalid || pop) begin
                if (skid_valid) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= skid_data;
                    m_axis_tlast  <= skid_last;
                    skid_valid    <= rd_valid;
                    skid_data     <= rd_data;
                    skid_last     <= rd_last;
                end else if (rd_valid) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= rd_data;
                    m_axis_tlast  <= rd_last;
                end else begin
                    m_axis_tvalid <= 1'b0;
                    m_axis_tlast  <= 1'b0;
                end
            end else if (rd_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= rd_data;
                skid_last  <= rd_last;
            end
        end
    end

endmodule

// File: tb/tb_ifft_frame_feeder.sv
// Directed/randomized bench for ifft_frame_feeder: an array model of the frame
// buffer predicts every output beat in index order.
module tb_ifft_frame_feeder;

    localparam int DW = 80;
    localparam int AW = 12;
    localparam int N  = 4096;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] bin_data = '0;
    logic [AW-1:0] bin_k = '0;
    logic          bin_valid = 1'b0;
    logic          bin_last = 1'b0;
    logic          bin_ready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic          frame_done;
    logic          overrun_err;
    logic          length_err;
    logic          err_clear = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_mem [N];

    ifft_frame_feeder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_BINS(N)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .bin_data      (bin_data),
        .bin_k         (bin_k),
        .bin_valid     (bin_valid),
        .bin_last      (bin_last),
        .bin_ready     (bin_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .frame_done    (frame_done),
        .overrun_err   (overrun_err),
        .length_err    (length_err),
        .err_clear     (err_clear)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // order: 0 ascending, 1 descending, 2 shuffled; kdata selects {k,~k} payload
    task automatic write_frame(input int n, input int order, input bit kdata, input bit exp_len);
        int ks[$];
        int j, tmp, k;
        logic [95:0] r;
        logic [DW-1:0] d;
        for (int i = 0; i < N; i++) ks.push_back(order == 1 ? N - 1 - i : i);
        if (order == 2) begin
            for (int i = N - 1; i > 0; i--) begin
                j = int'($urandom_range(i));
                tmp = ks[i]; ks[i] = ks[j]; ks[j] = tmp;
            end
        end
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(15) == 0) tick();
            chk("bin_ready_fill", bin_ready, 1);
            k = ks[i];
            r = {$urandom, $urandom, $urandom};
            d = kdata ? {40'(k), ~40'(k)} : r[DW-1:0];
            bin_valid = 1'b1;
            bin_k     = AW'(k);
            bin_data  = d;
            bin_last  = (i == n - 1);
            tick();
            bin_valid = 1'b0;
            bin_last  = 1'b0;
            exp_mem[k] = d;
        end
        chk("bin_ready_drain", bin_ready, 0);
        chk("length_err", length_err, exp_len);
    endtask

    task automatic drain(input int duty, input int ov_beat, input int rst_beat);
        int beat = 0;
        int cyc = 0;
        bit stall = 0, ov_pend = 0, injected = 0, hs;
        logic [DW-1:0] hd;
        logic hl;
        chk("tvalid_lat0", m_axis_tvalid, 0);
        tick();
        chk("tvalid_lat1", m_axis_tvalid, 0);
        tick();
        chk("tvalid_lat2", m_axis_tvalid, 1);
        while (beat < N && cyc < 20000) begin
            cyc++;
            if (ov_pend) begin
                bin_valid = 1'b0;
                ov_pend = 0;
                chk("overrun_set", overrun_err, 1);
            end
            if (stall) begin
                chk("hold_valid", m_axis_tvalid, 1);
                chk("hold_data", m_axis_tdata, hd);
                chk("hold_last", m_axis_tlast, hl);
            end
            if (beat == rst_beat) begin
                #2 reset_n = 1'b0;
                #1;
                chk("rst_tvalid", m_axis_tvalid, 0);
                chk("rst_tlast", m_axis_tlast, 0);
                chk("rst_tdata", m_axis_tdata, 0);
                chk("rst_frame_done", frame_done, 0);
                chk("rst_bin_ready", bin_ready, 1);
                chk("rst_overrun", overrun_err, 0);
                chk("rst_length", length_err, 0);
                m_axis_tready = 1'b0;
                repeat (2) @(posedge clock);
                #3 reset_n = 1'b1;
                tick();
                chk("post_rst_bin_ready", bin_ready, 1);
                chk("post_rst_tvalid", m_axis_tvalid, 0);
                return;
            end
            if (beat == ov_beat && !injected) begin
                bin_valid = 1'b1;
                bin_k     = AW'(5);
                bin_data  = {10{8'hAA}};
                bin_last  = 1'b0;
                injected  = 1;
                ov_pend   = 1;
            end
            m_axis_tready = (int'($urandom_range(99)) < duty);
            #1;
            hs = m_axis_tvalid && m_axis_tready;
            chk("frame_done", frame_done, hs && beat == N - 1);
            if (hs) begin
                chk("tdata", m_axis_tdata, exp_mem[beat]);
                chk("tlast", m_axis_tlast, beat == N - 1);
                beat++;
            end
            stall = m_axis_tvalid && !m_axis_tready;
            hd = m_axis_tdata;
            hl = m_axis_tlast;
            tick();
        end
        m_axis_tready = 1'b0;
        bin_valid = 1'b0;
        if (beat < N) chk("drain_timeout", 80'(beat), 80'(N));
        chk("tvalid_after", m_axis_tvalid, 0);
        chk("bin_ready_after", bin_ready, 1);
        chk("frame_done_after", frame_done, 0);
    endtask

    initial begin
        #12;
        chk("reset_bin_ready", bin_ready, 1);
        chk("reset_tvalid", m_axis_tvalid, 0);
        chk("reset_tlast", m_axis_tlast, 0);
        chk("reset_tdata", m_axis_tdata, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_overrun", overrun_err, 0);
        chk("reset_length", length_err, 0);
        reset_n = 1'b1;
        tick();

        // ascending {k,~k}, tready always high
        write_frame(N, 0, 1, 0);
        drain(100, -1, -1);

        // shuffled random data, 30% tready duty
        write_frame(N, 2, 0, 0);
        drain(30, -1, -1);
        chk("overrun_clean", overrun_err, 0);

        // descending k, last on k=0
        write_frame(N, 1, 1, 0);
        drain(70, -1, -1);

        // short frame: 100 bins then last
        write_frame(100, 2, 0, 1);
        drain(90, -1, -1);
        chk("length_err_held", length_err, 1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("length_err_cleared", length_err, 0);

        // overrun attempt on k=5 while draining
        write_frame(N, 0, 0, 0);
        drain(100, 2, -1);
        chk("overrun_held", overrun_err, 1);
        chk("length_err_clean", length_err, 0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("overrun_cleared", overrun_err, 0);

        // reset in the middle of a drain, then a fresh frame
        write_frame(N, 2, 0, 0);
        drain(100, -1, 1000);
        write_frame(N, 2, 0, 0);
        drain(80, -1, -1);
        chk("final_overrun", overrun_err, 0);
        chk("final_length", length_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
